// File: rtl/timer_pkg.sv
// Shared definitions for the BCD round-timer: FSM state encoding,
// digit width and the BCD digit clamp used when loading start values.
package timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Any non-BCD code (10..15) on a load input saturates to 9.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit counting downward. Wraps 0 -> 9 on decrement and flags a
// borrow so digits can be chained (ones borrow feeds tens dec_en).
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             dec_en,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  // Digit register: load has priority over decrement.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec_en) begin
      digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign borrow_out = (digit == '0) && dec_en;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD round timer (99..00). Counts down one step per prescaled
// tick while running, supports pause/resume, and parks at 00 in EXPIRED
// with a one-cycle timeout pulse on entry.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | value loaded, waiting for start
//   ST_RUN     | prescaler advancing, digits decrement on each tick
//   ST_PAUSED  | prescaler and digits frozen, waiting for start
//   ST_EXPIRED | reached 00; only load or reset leaves
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int DIV_W    = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_tens,
  input  logic [BCD_W-1:0] load_ones,
  input  logic             start,
  input  logic             pause,
  output logic [BCD_W-1:0] tens_out,
  output logic [BCD_W-1:0] ones_out,
  output logic             running,
  output logic             expired,
  output logic             timeout
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);

  state_t           state, state_next;
  logic [DIV_W-1:0] prescaler;
  logic             tick;
  logic             go;
  logic             ones_borrow;
  logic             tens_borrow;
  logic             value_zero;
  logic             value_one;

  // load outranks pause, which outranks start; a tick only survives when
  // neither load nor pause is asserted in the same cycle.
  assign go         = start && !pause;
  assign tick       = (state == ST_RUN) && !load && !pause && (prescaler == TICK_LAST);
  assign value_zero = (tens_out == '0) && (ones_out == '0);
  assign value_one  = (tens_out == '0) && (ones_out == 4'd1);

  bcd_digit_down u_ones (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (bcd_clamp(load_ones)),
    .dec_en     (tick),
    .digit      (ones_out),
    .borrow_out (ones_borrow)
  );

  bcd_digit_down u_tens (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (bcd_clamp(load_tens)),
    .dec_en     (ones_borrow),
    .digit      (tens_out),
    .borrow_out (tens_borrow)
  );

  // Prescaler advances only while running and unpaused, so a pause keeps
  // the partial tick and resume neither loses nor repeats it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescaler <= '0;
    end else if (load) begin
      prescaler <= '0;
    end else if ((state == ST_RUN) && !pause) begin
      prescaler <= (prescaler == TICK_LAST) ? '0 : prescaler + DIV_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A tick out of 01 lands on 00 and expires on the same
  // edge; tens_borrow would mean a tick below 00, so it also forces EXPIRED
  // rather than letting the count wrap.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go) state_next = value_zero ? ST_EXPIRED : ST_RUN;
        end
        ST_RUN: begin
          if (pause)                             state_next = ST_PAUSED;
          else if (tick && (value_one || tens_borrow)) state_next = ST_EXPIRED;
        end
        ST_PAUSED: begin
          if (go) state_next = ST_RUN;
        end
        ST_EXPIRED: state_next = ST_EXPIRED;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  // Timeout pulse: high for the first cycle spent in EXPIRED only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state_next == ST_EXPIRED) && (state != ST_EXPIRED);
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    running = (state == ST_RUN);
    expired = (state == ST_EXPIRED);
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with TICK_DIV=4. A reference
// model tracks the timer as an integer 0..99 plus a mode and a cycle count.
module tb_bcd_countdown_timer;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic [3:0] tens_out;
  logic [3:0] ones_out;
  logic       running;
  logic       expired;
  logic       timeout;

  int nvec = 0;
  int nerr = 0;

  // reference model: m_mode 0 idle, 1 run, 2 paused, 3 expired
  int m_val  = 0;
  int m_cnt  = 0;
  int m_mode = 0;
  bit m_to   = 1'b0;

  bcd_countdown_timer #(.TICK_DIV(TICK_DIV), .DIV_W(26)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_tens (load_tens),
    .load_ones (load_ones),
    .start     (start),
    .pause     (pause),
    .tens_out  (tens_out),
    .ones_out  (ones_out),
    .running   (running),
    .expired   (expired),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic int clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic logic [10:0] mk(input int t, input int o, input bit r, input bit e, input bit to);
    return {4'(t), 4'(o), r, e, to};
  endfunction

  function automatic logic [10:0] obs_vec();
    return {tens_out, ones_out, running, expired, timeout};
  endfunction

  function automatic logic [10:0] exp_vec();
    return mk(m_val / 10, m_val % 10, m_mode == 1, m_mode == 3, m_to);
  endfunction

  task automatic model_edge();
    bit go;
    go = start && !pause;
    m_to = 1'b0;
    if (!rst) begin
      m_val = 0; m_cnt = 0; m_mode = 0;
    end else if (load) begin
      m_val = clamp9(load_tens) * 10 + clamp9(load_ones);
      m_cnt = 0; m_mode = 0;
    end else begin
      case (m_mode)
        0: if (go) begin
             if (m_val == 0) begin m_mode = 3; m_to = 1'b1; end
             else m_mode = 1;
           end
        1: if (pause) m_mode = 2;
           else begin
             m_cnt = m_cnt + 1;
             if (m_cnt == TICK_DIV) begin
               m_cnt = 0;
               m_val = m_val - 1;
               if (m_val == 0) begin m_mode = 3; m_to = 1'b1; end
             end
           end
        2: if (go) m_mode = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_tens = 4'd0; load_ones = 4'd0;
  endtask

  task automatic do_load(input logic [3:0] t, input logic [3:0] o);
    load = 1'b1; load_tens = t; load_ones = o;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step(); step();
    rst = 1'b1;
    nvec++;
    if (obs_vec() !== mk(0, 0, 0, 0, 0)) begin
      nerr++; $display("FAIL reset_init: got %h want %h", obs_vec(), mk(0, 0, 0, 0, 0));
    end
    do_load(4'd3, 4'd7);
    do_start();
    step(); step();
    nvec++;
    if (obs_vec() !== mk(3, 7, 1, 0, 0)) begin
      nerr++; $display("FAIL reset_prerun: got %h want %h", obs_vec(), mk(3, 7, 1, 0, 0));
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    nvec++;
    if (obs_vec() !== mk(0, 0, 0, 0, 0)) begin
      nerr++; $display("FAIL reset_midrun: got %h want %h", obs_vec(), mk(0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_borrow();
    do_load(4'd1, 4'd2);
    do_start();
    repeat (3) step();
    nvec++;
    if (obs_vec() !== mk(1, 2, 1, 0, 0)) begin
      nerr++; $display("FAIL borrow_latency: got %h want %h", obs_vec(), mk(1, 2, 1, 0, 0));
    end
    step();
    nvec++;
    if (obs_vec() !== mk(1, 1, 1, 0, 0)) begin
      nerr++; $display("FAIL borrow_11: got %h want %h", obs_vec(), mk(1, 1, 1, 0, 0));
    end
    repeat (4) step();
    nvec++;
    if (obs_vec() !== mk(1, 0, 1, 0, 0)) begin
      nerr++; $display("FAIL borrow_10: got %h want %h", obs_vec(), mk(1, 0, 1, 0, 0));
    end
    repeat (4) step();
    nvec++;
    if (obs_vec() !== mk(0, 9, 1, 0, 0)) begin
      nerr++; $display("FAIL borrow_09: got %h want %h", obs_vec(), mk(0, 9, 1, 0, 0));
    end
  endtask

  task automatic test_expire();
    do_load(4'd0, 4'd2);
    do_start();
    repeat (4) step();
    nvec++;
    if (obs_vec() !== mk(0, 1, 1, 0, 0)) begin
      nerr++; $display("FAIL expire_01: got %h want %h", obs_vec(), mk(0, 1, 1, 0, 0));
    end
    repeat (4) step();
    nvec++;
    if (obs_vec() !== mk(0, 0, 0, 1, 1)) begin
      nerr++; $display("FAIL expire_entry: got %h want %h", obs_vec(), mk(0, 0, 0, 1, 1));
    end
    step();
    nvec++;
    if (obs_vec() !== mk(0, 0, 0, 1, 0)) begin
      nerr++; $display("FAIL expire_pulse_once: got %h want %h", obs_vec(), mk(0, 0, 0, 1, 0));
    end
    repeat (10) step();
    nvec++;
    if (obs_vec() !== mk(0, 0, 0, 1, 0)) begin
      nerr++; $display("FAIL expire_nowrap: got %h want %h", obs_vec(), mk(0, 0, 0, 1, 0));
    end
  endtask

  task automatic test_pause();
    do_load(4'd0, 4'd5);
    do_start();
    repeat (6) step();
    pause = 1'b1;
    repeat (10) step();
    pause = 1'b0;
    nvec++;
    if (obs_vec() !== mk(0, 4, 0, 0, 0)) begin
      nerr++; $display("FAIL pause_hold: got %h want %h", obs_vec(), mk(0, 4, 0, 0, 0));
    end
    do_start();
    step();
    nvec++;
    if (obs_vec() !== mk(0, 4, 1, 0, 0)) begin
      nerr++; $display("FAIL pause_resume_early: got %h want %h", obs_vec(), mk(0, 4, 1, 0, 0));
    end
    step();
    nvec++;
    if (obs_vec() !== mk(0, 3, 1, 0, 0)) begin
      nerr++; $display("FAIL pause_resume_tick: got %h want %h", obs_vec(), mk(0, 3, 1, 0, 0));
    end
  endtask

  task automatic test_clamp();
    do_load(4'd12, 4'd15);
    nvec++;
    if (obs_vec() !== mk(9, 9, 0, 0, 0)) begin
      nerr++; $display("FAIL clamp_99: got %h want %h", obs_vec(), mk(9, 9, 0, 0, 0));
    end
    start = 1'b1; pause = 1'b1;
    repeat (3) step();
    start = 1'b0; pause = 1'b0;
    nvec++;
    if (obs_vec() !== mk(9, 9, 0, 0, 0)) begin
      nerr++; $display("FAIL start_pause_idle: got %h want %h", obs_vec(), mk(9, 9, 0, 0, 0));
    end
    do_load(4'd0, 4'd0);
    do_start();
    nvec++;
    if (obs_vec() !== mk(0, 0, 0, 1, 1)) begin
      nerr++; $display("FAIL zero_start: got %h want %h", obs_vec(), mk(0, 0, 0, 1, 1));
    end
  endtask

  task automatic test_expired_hold();
    step();
    do_start();
    pause = 1'b1; step(); pause = 1'b0;
    nvec++;
    if (obs_vec() !== mk(0, 0, 0, 1, 0)) begin
      nerr++; $display("FAIL expired_ignore: got %h want %h", obs_vec(), mk(0, 0, 0, 1, 0));
    end
    do_load(4'd2, 4'd0);
    nvec++;
    if (obs_vec() !== mk(2, 0, 0, 0, 0)) begin
      nerr++; $display("FAIL expired_reload: got %h want %h", obs_vec(), mk(2, 0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    do_load(4'd0, 4'd3);
    do_start();
    repeat (3) step();
    do_load(4'd4, 4'd4);
    nvec++;
    if (obs_vec() !== mk(4, 4, 0, 0, 0)) begin
      nerr++; $display("FAIL load_beats_tick: got %h want %h", obs_vec(), mk(4, 4, 0, 0, 0));
    end
    do_start();
    repeat (4) step();
    nvec++;
    if (obs_vec() !== mk(4, 3, 1, 0, 0)) begin
      nerr++; $display("FAIL reload_restart: got %h want %h", obs_vec(), mk(4, 3, 1, 0, 0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 199) != 0);
      load      = ($urandom_range(0, 29) == 0);
      start     = ($urandom_range(0, 4) == 0);
      pause     = ($urandom_range(0, 9) == 0);
      load_tens = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      load_ones = 4'($urandom_range(0, 15));
      step();
      nvec++;
      if (obs_vec() !== exp_vec()) begin
        nerr++; $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_borrow();
    test_expire();
    test_pause();
    test_clamp();
    test_expired_hold();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
